// File: rtl/fifo_rd_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_arbiter_if
// Description : Consumer/FIFO-side bundle of the FIFO read-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_rd_arbiter_if #(
    parameter int NREQ = 4,
    parameter int ID_W = 2
);
    logic [NREQ-1:0] req;
    logic            empty;
    logic            r_en;
    logic [NREQ-1:0] gnt;
    logic            busy;
    logic            rd_valid;
    logic [ID_W-1:0] rd_id;

    // Environment side: consumers plus the read-pointer handler.
    modport master (
        output req,
        output empty,
        input  r_en,
        input  gnt,
        input  busy,
        input  rd_valid,
        input  rd_id
    );

    // Arbiter side.
    modport slave (
        input  req,
        input  empty,
        output r_en,
        output gnt,
        output busy,
        output rd_valid,
        output rd_id
    );
endinterface
`default_nettype wire

// File: rtl/fifo_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_arbiter
// Description : Round-robin, burst-limited arbiter sharing the async FIFO read
//               port among NREQ consumers; every pop is tagged with its owner.
//               Optional empty-stall release: FIFO_RD_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_arbiter #(
    parameter int NREQ      = 4,
    parameter int ID_W      = 2,
    parameter int MAX_BURST = 4,
    parameter int TIMEOUT   = 8
) (
    input  wire logic         rclk,
    input  wire logic         rrst,
    fifo_rd_arbiter_if.slave  bus
);

    localparam int BCNT_W = $clog2(MAX_BURST) + 1;
    localparam logic [BCNT_W-1:0] C_BCNT_LAST = BCNT_W'(MAX_BURST - 1);
    localparam logic [ID_W-1:0]   C_LAST_RST  = ID_W'(NREQ - 1);

    if (NREQ < 2 || ID_W != $clog2(NREQ) || MAX_BURST < 1 || TIMEOUT < 1) begin : g_bad_params
        $error("fifo_rd_arbiter: illegal parameter set");
    end

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0] gidx_q, gidx_d;
    logic [ID_W-1:0] last_q, last_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic            rd_valid_q;
    logic [ID_W-1:0] rd_id_q;

    logic            w_sel_found;
    logic [ID_W-1:0] w_sel_idx;
    logic [NREQ-1:0] w_sel_onehot;
    logic            w_req_g;
    logic            w_pop;
    logic            w_stall_expire;

    // Search starts one past the last winner and wraps modulo NREQ.
    always_comb begin
        int cand;
        cand        = 0;
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = int'(last_q) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!w_sel_found && bus.req[cand]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = ID_W'(cand);
            end
        end
    end

    assign w_sel_onehot = {{(NREQ-1){1'b0}}, 1'b1} << w_sel_idx;
    assign w_req_g      = bus.req[gidx_q];
    assign w_pop        = (state_q == S_BURST) && w_req_g && !bus.empty;

`ifdef FIFO_RD_ARB_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT + 1);
    localparam logic [STALL_W-1:0] C_STALL_MAX = STALL_W'(TIMEOUT);

    logic [STALL_W-1:0] stall_q, stall_d;

    // Held at zero outside a burst, so every new grant starts a fresh count.
    always_comb begin
        stall_d        = stall_q;
        w_stall_expire = 1'b0;
        if (state_q == S_IDLE || w_pop) begin
            stall_d = '0;
        end else if (w_req_g && bus.empty) begin
            stall_d = stall_q + 1'b1;
            if (stall_d == C_STALL_MAX) begin
                w_stall_expire = 1'b1;
            end
        end
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end
`else
    assign w_stall_expire = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        bcnt_d  = bcnt_q;
        case (state_q)
            S_IDLE: begin
                if (w_sel_found) begin
                    state_d = S_BURST;
                    gnt_d   = w_sel_onehot;
                    gidx_d  = w_sel_idx;
                    last_d  = w_sel_idx;
                    bcnt_d  = '0;
                end
            end
            S_BURST: begin
                if (w_pop) begin
                    bcnt_d = bcnt_q + 1'b1;
                end
                // Clearing bcnt on release keeps it within 0..MAX_BURST-1.
                if ((w_pop && bcnt_q == C_BCNT_LAST) || !w_req_g || w_stall_expire) begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                    bcnt_d  = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                bcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            state_q    <= S_IDLE;
            gnt_q      <= '0;
            gidx_q     <= '0;
            last_q     <= C_LAST_RST;
            bcnt_q     <= '0;
            rd_valid_q <= 1'b0;
            rd_id_q    <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gidx_q     <= gidx_d;
            last_q     <= last_d;
            bcnt_q     <= bcnt_d;
            rd_valid_q <= w_pop;
            if (w_pop) begin
                rd_id_q <= gidx_q;
            end
        end
    end

    assign bus.r_en     = w_pop;
    assign bus.gnt      = gnt_q;
    assign bus.busy     = (state_q == S_BURST);
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_id    = rd_id_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_rd_arbiter
// Description : Directed scoreboard bench for fifo_rd_arbiter with a simple
//               FIFO occupancy model driving the empty flag.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_arbiter;

    localparam int NREQ      = 4;
    localparam int ID_W      = 2;
    localparam int MAX_BURST = 4;
    localparam int TIMEOUT   = 8;

    logic rclk = 1'b0;
    logic rrst = 1'b1;

    fifo_rd_arbiter_if #(.NREQ(NREQ), .ID_W(ID_W)) bus ();

    fifo_rd_arbiter #(
        .NREQ(NREQ), .ID_W(ID_W), .MAX_BURST(MAX_BURST), .TIMEOUT(TIMEOUT)
    ) u_dut (
        .rclk (rclk),
        .rrst (rrst),
        .bus  (bus.slave)
    );

    always #5 rclk = ~rclk;

    // FIFO occupancy model: empty is a registered function of the word count.
    logic load     = 1'b1;
    int   load_val = 0;
    int   cnt      = 0;
    always @(posedge rclk) begin
        if (load) cnt <= load_val;
        else if (bus.r_en && cnt > 0) cnt <= cnt - 1;
    end
    assign bus.empty = (cnt == 0);

    int checks   = 0;
    int failures = 0;
    logic [ID_W-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every tagged pop must match the next expected owner.
    always @(negedge rclk) begin
        if (bus.rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: got rd_valid with rd_id=%0d expected no pop", bus.rd_id);
            end else begin
                chk("sb_rd_id", 32'(bus.rd_id), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic cyc();
        @(posedge rclk);
        #1;
    endtask

    task automatic do_reset();
        bus.req  = '0;
        load     = 1'b1;
        load_val = 0;
        rrst     = 1'b1;
        cyc();
        cyc();
        rrst = 1'b0;
        load = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [14:0] pat;
        logic [19:0] seq;
        logic [3:0]  prev;
        int          gcnt;
        int          held;
        int          rcnt;

        // Reset defaults
        do_reset();
        @(negedge rclk);
        chk("rst_gnt", 32'(bus.gnt), 32'h0);
        chk("rst_r_en", 32'(bus.r_en), 32'h0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);

        // Single requester, 10 words: bursts 4,4,2 with bubbles
        cyc();
        load = 1'b1; load_val = 10; bus.req = 4'b0001;
        for (int i = 0; i < 10; i++) exp_q.push_back(2'd0);
        cyc();
        load = 1'b0;
        pat = '0;
        for (int i = 0; i < 15; i++) begin
            @(negedge rclk);
            pat[14-i] = bus.r_en;
            if (i < 14) cyc();
        end
        chk("single_r_en_pattern", 32'(pat), 32'(15'b111101111011000));
        chk("single_gnt_held", 32'(bus.gnt), 32'h1);
        chk("single_busy_held", 32'(bus.busy), 32'h1);
        bus.req = 4'b0000;
        cyc();
        @(negedge rclk);
        chk("single_gnt_drop", 32'(bus.gnt), 32'h0);
        chk("single_busy_drop", 32'(bus.busy), 32'h0);
        chk("single_sb_drain", 32'(exp_q.size()), 32'h0);

        // Round-robin, all requesting, FIFO never empty
        do_reset();
        load = 1'b1; load_val = 1000; bus.req = 4'b1111;
        for (int r = 0; r < 5; r++)
            for (int p = 0; p < MAX_BURST; p++) exp_q.push_back(ID_W'(r % NREQ));
        cyc();
        load = 1'b0;
        seq = '0; prev = '0; gcnt = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge rclk);
            if (bus.gnt != 4'b0 && bus.gnt != prev) begin
                seq = {seq[15:0], bus.gnt};
                gcnt++;
            end
            prev = bus.gnt;
            if (i < 24) cyc();
        end
        bus.req = 4'b0000;
        cyc();
        cyc();
        @(negedge rclk);
        chk("rr_grant_order", 32'(seq), 32'h12481);
        chk("rr_grant_count", 32'(gcnt), 32'd5);
        chk("rr_sb_drain", 32'(exp_q.size()), 32'h0);

        // Early drop: requester 2 drops after 2 pops, requester 3 next
        do_reset();
        load = 1'b1; load_val = 1000; bus.req = 4'b1100;
        exp_q.push_back(2'd2);
        exp_q.push_back(2'd2);
        cyc();
        load = 1'b0;
        cyc();
        cyc();
        bus.req = 4'b1000;
        @(negedge rclk);
        chk("drop_r_en", 32'(bus.r_en), 32'h0);
        chk("drop_busy", 32'(bus.busy), 32'h1);
        cyc();
        @(negedge rclk);
        chk("drop_gnt_clear", 32'(bus.gnt), 32'h0);
        cyc();
        @(negedge rclk);
        chk("drop_next_gnt", 32'(bus.gnt), 32'b1000);
        chk("drop_rd_valid_low", 32'(bus.rd_valid), 32'h0);
        chk("drop_rd_id_hold", 32'(bus.rd_id), 32'd2);
        bus.req = 4'b0000;
        cyc();
        cyc();
        @(negedge rclk);
        chk("drop_sb_drain", 32'(exp_q.size()), 32'h0);

        // Empty stall: grant held (or released on timeout) with no pops
        do_reset();
        bus.req = 4'b0001;
        cyc();
        held = 0; rcnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge rclk);
            if (bus.gnt == 4'b0001) held++;
            if (bus.r_en) rcnt++;
            if (i < 19) cyc();
        end
`ifdef FIFO_RD_ARB_TIMEOUT_EN
        chk("stall_gnt_cycles", 32'(held), 32'd18);
`else
        chk("stall_gnt_cycles", 32'(held), 32'd20);
`endif
        chk("stall_r_en_cycles", 32'(rcnt), 32'd0);
        bus.req = 4'b0000;
        cyc();
        cyc();

        // Reset in the middle of a burst, during a pop cycle
        do_reset();
        load = 1'b1; load_val = 100; bus.req = 4'b0010;
        exp_q.push_back(2'd1);
        cyc();
        load = 1'b0;
        cyc();
        @(negedge rclk);
        chk("mid_rst_pop_before", 32'(bus.r_en), 32'h1);
        rrst = 1'b1;
        cyc();
        rrst = 1'b0;
        bus.req = 4'b1111;
        @(negedge rclk);
        chk("mid_rst_rd_valid", 32'(bus.rd_valid), 32'h0);
        chk("mid_rst_gnt", 32'(bus.gnt), 32'h0);
        chk("mid_rst_busy", 32'(bus.busy), 32'h0);
        cyc();
        @(negedge rclk);
        chk("mid_rst_next_gnt", 32'(bus.gnt), 32'b0001);
        bus.req = 4'b0000;
        cyc();
        cyc();
        @(negedge rclk);
        chk("mid_rst_sb_drain", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_rd_arbiter.md
# fifo_rd_arbiter

Read-side arbiter that shares the single read port of the asynchronous FIFO among several consumers. It sits in the read clock domain, in front of the read-pointer handler. It takes the handler's registered `empty` flag and drives its `r_en`. Grants are round-robin and bounded by a maximum burst length, and every accepted pop is tagged with the consumer it belongs to.

## Interface
- `NREQ`, 4 — number of requesters, ≥2.
- `ID_W`, 2 — width of requester index, equal to clog2(`NREQ`).
- `MAX_BURST`, 4 — maximum pops per grant, ≥1.
- `TIMEOUT`, 8 — empty-stall cycles before forced release (used only with the macro below), ≥1.

- `rclk` in 1 — read-domain clock.
- `rrst` in 1 — synchronous, active-high reset.
- `req` in `NREQ` — per-consumer read request, level-sensitive.
- `empty` in 1 — registered empty flag from the read-pointer handler.
- `r_en` out 1 — read enable to the read-pointer handler (combinational).
- `gnt` out `NREQ` — one-hot grant, registered; all-zero when idle.
- `busy` out 1 — high while a grant is held.
- `rd_valid` out 1 — registered; high the cycle after a pop.
- `rd_id` out `ID_W` — registered; index of the consumer owning the popped word.

## Operation
- States: IDLE, BURST.
- **IDLE**
  - `gnt` = 0, `r_en` = 0.
  - If `req` != 0, select the first set bit searching from (`last`+1) mod `NREQ` upward with wrap.
  - Load `gnt`, `last` ← selected index, burst counter `bcnt` ← 0, and go to BURST.
- **BURST**
  - `r_en` = `req[g] & !empty`, where g is the granted index.
  - A pop is a cycle with `r_en` = 1. Each pop increments `bcnt`.
- **BURST → IDLE** on the first of:
  - a pop with `bcnt` == `MAX_BURST`-1, or
  - `req[g]` == 0.
- While `empty` is high with `req[g]` high, stay in BURST, hold `gnt`, and keep `r_en` = 0. There is no release unless the macro is enabled.
- Every IDLE→BURST transition costs one bubble cycle. There is never more than one bit set in `gnt`.
- **Tagging**
  - `rd_valid` ← `r_en`.
  - `rd_id` ← g on every pop.
  - `rd_id` holds its last value when `rd_valid` = 0.
- **Simultaneous events**
  - A pop and the `req[g]` drop cannot coincide, because `r_en` requires `req[g]`.
  - A pop on the last burst slot releases even if `req[g]` stays high. The next arbitration then starts searching after g, so a lone requester is re-granted after one bubble.
  - `req` changes during BURST do not affect the current grant.
- **Reset values**
  - State IDLE; `gnt` 0, `busy` 0, `r_en` 0.
  - `rd_valid` 0, `rd_id` 0, `bcnt` 0.
  - `last` = `NREQ`-1, so requester 0 wins first.
- **Reset mid-burst**
  - State is discarded at the next edge and `rd_valid` for a pop in that cycle is suppressed.
  - `rrst` must be asserted together with the FIFO read-domain reset.
- **Arithmetic**
  - `bcnt` is clog2(`MAX_BURST`)+1 bits and never exceeds `MAX_BURST`-1.
  - The round-robin index is `ID_W` bits with mod-`NREQ` wrap; non-power-of-two `NREQ` is legal.

## Timing
- **Request to first pop:** `req` high at edge N (IDLE) → `gnt` valid after edge N+1 → earliest `r_en` in cycle N+1 (when `empty` = 0).
- **Pop to tag:** pop at edge M is reflected as `rd_valid`/`rd_id` after edge M+1. The FIFO word is sampled by the consumer on the same cycle.
- **Throughput:** one pop per cycle within a burst. Back-to-back bursts have a maximum duty of `MAX_BURST`/(`MAX_BURST`+1).
- **Release:** `gnt` drops at the edge after the releasing condition.
- `r_en` is combinational from registered state, `req`, and `empty`, with no other path.

## Configuration
- **`FIFO_RD_ARB_TIMEOUT_EN` defined:**
  - An empty-stall counter runs in BURST. It counts cycles with `req[g]` & `empty` and clears on any pop.
  - When it reaches `TIMEOUT`, BURST → IDLE and the grant rotates.
  - The counter resets to 0 on grant.
- **Undefined:** there is no counter, and a granted requester holds the port indefinitely while `empty` is high.

## Test plan
- **Reset defaults:** `rrst` high 2 cycles, then `req`=4'b0000 → `gnt`=0, `r_en`=0, `rd_valid`=0, `busy`=0.
- **Single requester, 10 words:** `req`=4'b0001, FIFO holds 10 words, `MAX_BURST`=4.
  - Bursts of 4, 4, 2 with one bubble between bursts.
  - `rd_id`=0 for all 10 pops; `r_en` low once `empty` rises.
- **Round-robin:** `req`=4'b1111, FIFO always non-empty → grant order 0,1,2,3,0; each requester gets 4 pops; `rd_id` sequence matches.
- **Early drop:** requester 2 drops `req` after 2 pops → `gnt` clears next edge and the next grant goes to requester 3 if requesting.
- **Empty stall:** grant held with `empty`=1 for 20 cycles.
  - Macro undefined: `gnt` stays, `r_en`=0.
  - Macro defined with `TIMEOUT`=8: release at cycle 8 and the grant rotates.
- **Reset mid-burst:** `rrst` pulses in the pop cycle → `rd_valid`=0 next cycle; `gnt`=0; requester 0 wins the next arbitration.
